// File: rtl/tc_tile_sched_pkg.sv
// tc_tile_sched_pkg: shared types and constants for the tensorcore tile scheduler.
package tc_tile_sched_pkg;

   localparam int CFG_CNT_W = 32;
   localparam int CFG_KT_W = 16;

   localparam logic [2:0] SEL_C  = 3'b001;
   localparam logic [2:0] SEL_A  = 3'b010;
   localparam logic [2:0] SEL_B  = 3'b100;
   localparam logic [2:0] SEL_WB = 3'b000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_READ_C,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_SYSTOLIC,
      ST_ACCUMULATE,
      ST_WAIT_WRITE,
      ST_WRITE_BACK,
      ST_FINISH
   } state_e;

   typedef enum logic [1:0] {
      DT_FP32,
      DT_FP16,
      DT_INT8,
      DT_INT4
   } dtype_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_REQ,
      HS_WAIT
   } hs_e;

   // Fields are sized for the widest supported instance; the top narrows them.
   typedef struct packed {
      dtype_e                dtype;
      logic [CFG_KT_W-1:0]  k_tiles;
      logic [CFG_CNT_W-1:0] sys_time;
      logic [CFG_CNT_W-1:0] wb_time;
   } cfg_t;

   function automatic logic is_mem_state(input state_e s);
      return s inside {ST_READ_C, ST_LOAD_A, ST_LOAD_B, ST_WRITE_BACK};
   endfunction

   function automatic logic [2:0] sel_of(input state_e s);
      return s == ST_READ_C ? SEL_C : s == ST_LOAD_A ? SEL_A : s == ST_LOAD_B ? SEL_B : SEL_WB;
   endfunction

endpackage

// File: rtl/tc_mem_req_hs.sv
// tc_mem_req_hs: valid-until-ready request, wait-for-done completion and protocol error flag.
module tc_mem_req_hs
   import tc_tile_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       launch_i,
   input  logic [2:0] sel_i,
   input  logic       mem_req_ready_i,
   input  logic       mem_done_i,
   output logic       mem_req_valid_o,
   output logic [2:0] mem_sel_o,
   output logic       xfer_done_o,
   output logic       proto_err_o
);

   hs_e        hs_q, hs_d;
   logic [2:0] sel_q, sel_d;
   logic       err_q, err_d;

   assign mem_req_valid_o = hs_q == HS_REQ;
   assign mem_sel_o = sel_q;
   assign xfer_done_o = hs_q == HS_WAIT && mem_done_i;
   assign proto_err_o = err_q;

   // A done that arrives with the accept, or with nothing accepted, only raises the error.
   always_comb begin
      hs_d = hs_q;
      sel_d = sel_q;
      err_d = err_q | (mem_done_i && hs_q != HS_WAIT);
      if (launch_i) begin
         hs_d = HS_REQ;
         sel_d = sel_i;
      end else if (hs_q == HS_REQ && mem_req_ready_i) begin
         hs_d = HS_WAIT;
      end else if (xfer_done_o) begin
         hs_d = HS_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q <= HS_IDLE;
         sel_q <= '0;
         err_q <= 1'b0;
      end else begin
         hs_q <= hs_d;
         sel_q <= sel_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/tc_tile_sched.sv
// tc_tile_sched: sequences one GEMM tile job (fetch C, K sub-tile loop, drain, write-back).
module tc_tile_sched
   import tc_tile_sched_pkg::*;
#(
   parameter int L       = 8,
   parameter int CNT_W   = 16,
   parameter int KT_W    = 8,
   parameter int ACC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       cfg_dtype_i,
   input  logic [KT_W-1:0]  cfg_k_tiles_i,
   input  logic [CNT_W-1:0] cfg_sys_time_i,
   input  logic [CNT_W-1:0] cfg_wb_time_i,
   input  logic             stall_i,
   output logic             mem_req_valid_o,
   input  logic             mem_req_ready_i,
   output logic [2:0]       mem_sel_o,
   input  logic             mem_done_i,
   output logic             sa_flow_o,
   output logic             sa_clear_o,
   output logic             acc_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [KT_W-1:0]  k_idx_o,
   output logic             proto_err_o
);

   state_e           state_q, state_d, loop_st;
   cfg_t             cfg_q, cfg_d;
   logic [KT_W-1:0]  k_q, k_d, k_loop;
   logic [KT_W:0]    k_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d, wb_cnt;
   logic             clr_q, clr_d;
   logic             more_k, xfer_done, launch;

   assign k_nxt = {1'b0, k_q} + (KT_W + 1)'(1);
   assign more_k = k_nxt < (KT_W + 1)'(cfg_q.k_tiles);
   assign loop_st = more_k ? ST_LOAD_A : ST_WAIT_WRITE;
   assign k_loop = more_k ? k_nxt[KT_W-1:0] : k_q;
   assign wb_cnt = CNT_W'(cfg_q.wb_time);
   assign launch = state_d != state_q && is_mem_state(state_d);

   // cnt_q is shared: flow cycles left, accumulate cycles left, or drain cycles left.
   always_comb begin
      state_d = state_q;
      cfg_d = cfg_q;
      k_d = k_q;
      cnt_d = cnt_q;
      clr_d = 1'b0;
      case (state_q)
         ST_IDLE: if (start_i) begin
            state_d = ST_READ_C;
            cfg_d.dtype = dtype_e'(cfg_dtype_i);
            cfg_d.k_tiles = CFG_KT_W'(cfg_k_tiles_i == '0 ? KT_W'(1) : cfg_k_tiles_i);
            cfg_d.sys_time = CFG_CNT_W'(cfg_sys_time_i == '0 ? CNT_W'(1) : cfg_sys_time_i);
            cfg_d.wb_time = CFG_CNT_W'(cfg_wb_time_i);
            k_d = '0;
         end
         ST_READ_C: if (xfer_done) state_d = ST_LOAD_A;
         ST_LOAD_A: if (xfer_done) state_d = ST_LOAD_B;
         ST_LOAD_B: if (xfer_done) begin
            state_d = ST_SYSTOLIC;
            cnt_d = CNT_W'(cfg_q.sys_time);
            clr_d = 1'b1;
         end
         ST_SYSTOLIC: if (!stall_i) begin
            if (cnt_q != CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (cfg_q.dtype == DT_INT4) begin
               state_d = ST_ACCUMULATE;
               cnt_d = CNT_W'(ACC_LAT);
            end else begin
               state_d = loop_st;
               k_d = k_loop;
               cnt_d = wb_cnt;
            end
         end
         ST_ACCUMULATE: if (cnt_q != CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            state_d = loop_st;
            k_d = k_loop;
            cnt_d = wb_cnt;
         end
         ST_WAIT_WRITE: if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);
            else state_d = ST_WRITE_BACK;
         ST_WRITE_BACK: if (xfer_done) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cfg_q <= '0;
         k_q <= '0;
         cnt_q <= '0;
         clr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q <= cfg_d;
         k_q <= k_d;
         cnt_q <= cnt_d;
         clr_q <= clr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q != ST_IDLE)
         assert (L > 0 && {1'b0, k_q} < (KT_W + 1)'(cfg_q.k_tiles));
   end

   tc_mem_req_hs u_hs (
      .clk             (clk),
      .rst             (rst),
      .launch_i        (launch),
      .sel_i           (sel_of(state_d)),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_done_i      (mem_done_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_sel_o       (mem_sel_o),
      .xfer_done_o     (xfer_done),
      .proto_err_o     (proto_err_o)
   );

   assign sa_flow_o = state_q == ST_SYSTOLIC && !stall_i;
   assign sa_clear_o = clr_q;
   assign acc_en_o = state_q == ST_ACCUMULATE;
   assign busy_o = state_q != ST_IDLE;
   assign done_o = state_q == ST_FINISH;
   assign k_idx_o = k_q;

endmodule

// File: tb/tb_tc_tile_sched.sv
// tb_tc_tile_sched: directed and randomized jobs checked against per-job totals derived from the job rules.
module tb_tc_tile_sched;

   localparam int CNT_W = 16;
   localparam int KT_W = 8;
   localparam int ACC_LAT = 2;
   localparam int TO = 20000;

   logic clk = 0, rst = 1, start = 0, stall = 0;
   logic [1:0] dt_i = 0;
   logic [KT_W-1:0] kt_i = 0;
   logic [CNT_W-1:0] st_i = 0, wt_i = 0;
   logic ready = 0, r_done = 0, inj_done = 0, mem_done;
   logic valid, flow, clear, acc, busy, done, perr;
   logic [2:0] sel;
   logic [KT_W-1:0] k_idx;

   int tests = 0, fails = 0;

   assign mem_done = r_done | inj_done;

   tc_tile_sched #(.L(8), .CNT_W(CNT_W), .KT_W(KT_W), .ACC_LAT(ACC_LAT)) dut (
      .clk(clk), .rst(rst), .start_i(start), .cfg_dtype_i(dt_i), .cfg_k_tiles_i(kt_i),
      .cfg_sys_time_i(st_i), .cfg_wb_time_i(wt_i), .stall_i(stall),
      .mem_req_valid_o(valid), .mem_req_ready_i(ready), .mem_sel_o(sel), .mem_done_i(mem_done),
      .sa_flow_o(flow), .sa_clear_o(clear), .acc_en_o(acc), .busy_o(busy), .done_o(done),
      .k_idx_o(k_idx), .proto_err_o(perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Observation log, sampled mid-cycle.
   int cyc = 0, flow_n = 0, clr_n = 0, acc_n = 0, done_n = 0, stab_n = 0;
   int t_act_last = 0, t_flow_last = 0, run = 0;
   int sel_log[$], k_log[$], wb_t[$], run_b[$], t_clr[$];
   logic pv = 0;
   logic [2:0] psel = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (flow) begin
         flow_n++;
         t_flow_last = cyc;
      end
      if (flow || acc) t_act_last = cyc;
      if (clear) begin
         clr_n++;
         k_log.push_back(int'(k_idx));
         t_clr.push_back(cyc);
      end
      if (acc) acc_n++;
      if (done) done_n++;
      if (valid && !pv) begin
         sel_log.push_back(int'(sel));
         if (sel == 3'b000) wb_t.push_back(cyc);
      end
      if (valid && pv && sel != psel) stab_n++;
      if (valid) run++;
      else begin
         if (pv && psel == 3'b100) run_b.push_back(run);
         run = 0;
      end
      pv = valid;
      psel = sel;
   end

   // Memory responder: ready after a chosen delay, done a chosen delay after accept.
   int r_ph = 0, r_cnt = 0, rd_lo = 0, rd_hi = 2, dd_lo = 0, dd_hi = 2;
   bit force_b7 = 0;
   always @(posedge clk) begin
      #2;
      ready = 0;
      r_done = 0;
      if (rst) r_ph = 0;
      else begin
         if (r_ph == 0 && valid) begin
            r_cnt = (force_b7 && sel == 3'b100) ? 7 : int'($urandom_range(rd_hi, rd_lo));
            r_ph = 1;
         end
         if (r_ph == 1) begin
            if (r_cnt == 0) begin
               ready = 1;
               r_ph = 2;
               r_cnt = int'($urandom_range(dd_hi, dd_lo));
            end else r_cnt--;
         end else if (r_ph == 2) begin
            if (r_cnt == 0) begin
               r_done = 1;
               r_ph = 0;
            end else r_cnt--;
         end
      end
   end

   int stall_mode = 0;
   always @(posedge clk) begin
      #1;
      stall = stall_mode == 0 ? 1'b0 : stall_mode == 1 ? ~stall : 1'($urandom_range(1, 0));
   end

   task automatic start_job(input logic [1:0] dt, input int kt, input int st, input int wt);
      @(posedge clk);
      #1;
      dt_i = dt;
      kt_i = KT_W'(kt);
      st_i = CNT_W'(st);
      wt_i = CNT_W'(wt);
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic run_job(input logic [1:0] dt, input int kt, input int st, input int wt,
                          input bit inj, input logic exp_perr);
      int f0 = flow_n, a0 = acc_n, c0 = clr_n, d0 = done_n, sb0 = stab_n;
      int s0 = sel_log.size(), k0 = k_log.size(), w0 = wb_t.size();
      int ktp = kt == 0 ? 1 : kt, stp = st == 0 ? 1 : st, wtp = wt == 0 ? 1 : wt;
      int n = 0, ww;
      int q[$];
      bit ok;
      start_job(dt, kt, st, wt);
      if (inj) begin
         repeat (3) @(posedge clk);
         #1;
         dt_i = ~dt;
         kt_i = 5;
         st_i = 9;
         start = 1;
         @(posedge clk);
         #1;
         start = 0;
      end
      @(negedge clk);
      while (done !== 1'b1 && n < TO) begin
         @(negedge clk);
         n++;
      end
      chk("job_done_seen", done, 1);
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      #1;
      chk("idle_after_done", {busy, done}, 0);
      chk("flow_cycles", flow_n - f0, ktp * stp);
      chk("acc_cycles", acc_n - a0, dt == 2'b11 ? ktp * ACC_LAT : 0);
      chk("clear_pulses", clr_n - c0, ktp);
      ok = 1;
      for (int i = 0; i < ktp; i++)
         if (k0 + i >= k_log.size() || k_log[k0 + i] != i) ok = 0;
      chk("k_idx_sequence", ok, 1);
      q.push_back(1);
      for (int i = 0; i < ktp; i++) begin
         q.push_back(2);
         q.push_back(4);
      end
      q.push_back(0);
      ok = sel_log.size() - s0 == q.size();
      for (int i = 0; i < q.size(); i++)
         if (ok && sel_log[s0 + i] != q[i]) ok = 0;
      chk("sel_sequence", ok, 1);
      chk("done_pulses", done_n - d0, 1);
      ww = wb_t.size() > w0 ? wb_t[$] - t_act_last - 1 : -1;
      chk("wait_write_cycles", ww, wtp);
      chk("sel_stable", stab_n - sb0, 0);
      chk("proto_err", perr, exp_perr);
   endtask

   initial begin
      int n, dur;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("reset_outputs", {valid, sel, flow, clear, acc, busy, done, k_idx, perr}, 0);

      rd_lo = 1; rd_hi = 1; dd_lo = 1; dd_hi = 1;
      run_job(2'b00, 1, 4, 2, 0, 0);
      rd_lo = 0; rd_hi = 2; dd_lo = 0; dd_hi = 2;

      run_job(2'b11, 3, 2, int'($urandom_range(3, 0)), 0, 0);

      stall_mode = 1;
      run_job(2'b01, 1, 5, 1, 0, 0);
      dur = t_flow_last - t_clr[$] + 1;
      chk("systolic_span_9_to_10", dur >= 9 && dur <= 10, 1);
      stall_mode = 0;

      force_b7 = 1;
      run_job(2'b10, 1, 3, 1, 0, 0);
      chk("load_b_valid_hold", run_b.size() > 0 ? run_b[$] : -1, 8);
      force_b7 = 0;

      @(posedge clk);
      #1;
      inj_done = 1;
      @(posedge clk);
      #1;
      inj_done = 0;
      @(negedge clk);
      chk("proto_err_idle_done", perr, 1);
      run_job(2'b00, 2, 3, 0, 0, 1);
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("proto_err_cleared", perr, 0);

      start_job(2'b00, 2, 40, 1);
      n = 0;
      @(negedge clk);
      while (flow !== 1'b1 && n < TO) begin
         @(negedge clk);
         n++;
      end
      chk("reached_systolic", flow, 1);
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("mid_job_reset_outputs", {valid, sel, flow, clear, acc, busy, done, k_idx, perr}, 0);
      run_job(2'b10, 2, 3, 2, 0, 0);

      run_job(2'b01, 0, 0, 0, 1, 0);
      repeat (3) @(negedge clk);
      chk("ignored_start_no_job", busy, 0);

      stall_mode = 2;
      for (int j = 0; j < 8; j++)
         run_job(2'($urandom_range(3, 0)), int'($urandom_range(4, 0)), int'($urandom_range(6, 0)),
                 int'($urandom_range(3, 0)), 0, 0);
      stall_mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
